// File: rtl/up_down_counter_if.sv
// Control and status bundle for up_down_counter: stimulus drives the master side,
// the counter implements the slave side.
interface up_down_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             inc_dec;
  logic [WIDTH-1:0] start_value;
  logic [WIDTH-1:0] count_out;
  logic             wrap;

  modport master (
    output enable,
    output inc_dec,
    output start_value,
    input  count_out,
    input  wrap
  );

  modport slave (
    input  enable,
    input  inc_dec,
    input  start_value,
    output count_out,
    output wrap
  );
endinterface

// File: rtl/up_down_counter.sv
// Loadable up/down counter with enable; areset doubles as the start_value load strobe.
// Define UP_DOWN_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module up_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  up_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Next count and crossing detection; wrap_d only rises on an enabled edge that crosses an end.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.enable) begin
      if (!bus.inc_dec) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
`else
        cnt_d  = cnt_q + CNT_ONE;
        wrap_d = (cnt_q == CNT_MAX);
`endif
      end else begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
`else
        cnt_d  = cnt_q - CNT_ONE;
        wrap_d = (cnt_q == CNT_ZERO);
`endif
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q  <= bus.start_value;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count_out = cnt_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed vector table, wrap/saturate
// corner sequences, and randomized traffic against an integer reference model.
module tb_up_down_counter;

  localparam int unsigned W    = 8;
  localparam int          MAXV = (1 << W) - 1;

  typedef struct {
    logic           rst;
    logic           en;
    logic           dir;
    logic [W-1:0]   sv;
    int             reps;
    logic [W-1:0]   exp_cnt;
    logic           exp_wrap;
  } vec_t;

  logic aclk = 1'b0;
  logic areset;
  int   n_checks = 0;
  int   n_fail   = 0;

  up_down_counter_if #(.WIDTH(W)) bus();

  up_down_counter #(.WIDTH(W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [W-1:0] sv);
    areset          = r;
    bus.enable      = e;
    bus.inc_dec     = d;
    bus.start_value = sv;
    @(posedge aclk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic r, input logic e, input logic d,
                          input logic [W-1:0] sv, input logic [W-1:0] ec, input logic ew);
    step(r, e, d, sv);
    check({name, ".count"}, 32'(bus.count_out), 32'(ec));
    check({name, ".wrap"},  32'(bus.wrap),      32'(ew));
  endtask

  vec_t vecs[$];

  // Reference model: plain integer arithmetic, out-of-range result means a crossing.
  int m_cnt;
  bit m_wrap;

  task automatic model_edge(input logic r, input logic e, input logic d, input logic [W-1:0] sv);
    int n;
    if (r) begin
      m_cnt  = int'(sv);
      m_wrap = 1'b0;
    end else if (e) begin
      n = d ? m_cnt - 1 : m_cnt + 1;
      m_wrap = 1'b0;
      if (n < 0 || n > MAXV) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        n = m_cnt;
`else
        n      = (n < 0) ? MAXV : 0;
        m_wrap = 1'b1;
`endif
      end
      m_cnt = n;
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  initial begin
    areset          = 1'b0;
    bus.enable      = 1'b0;
    bus.inc_dec     = 1'b0;
    bus.start_value = '0;

    // rst en dir sv reps exp_cnt exp_wrap
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hAF, 10, 8'hAF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00,  3, 8'hAF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h12, 10, 8'hB9, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h34,  5, 8'hB9, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00,  2, 8'hBB, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hC0,  1, 8'hC0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hC0,  5, 8'hC5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hC0,  1, 8'hC4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hC0,  1, 8'hC3, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hC0,  4, 8'hBF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h55,  1, 8'h55, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h55,  1, 8'h55, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00,  1, 8'h56, 1'b0});

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++)
        step(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].sv);
      check($sformatf("vec%0d.count", i), 32'(bus.count_out), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d.wrap", i),  32'(bus.wrap),      32'(vecs[i].exp_wrap));
    end

    // Up crossing max -> 0, then pulse must clear on a hold edge
    step_chk("up_load", 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b0);
    step_chk("up_1",    1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    step_chk("up_2",    1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
    step_chk("up_3",    1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
    step_chk("up_hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
`else
    step_chk("up_2",    1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step_chk("up_3",    1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
    step_chk("up_hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
`endif

    // Down crossing 0 -> max
    step_chk("dn_load", 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    step_chk("dn_1",    1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    step_chk("dn_2",    1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    step_chk("dn_hold", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
`else
    step_chk("dn_2",    1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
    step_chk("dn_hold", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
`endif

    // Wrap pulse cleared by a reset landing right after a crossing
    step_chk("wr_load", 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    step_chk("wr_up",   1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
`else
    step_chk("wr_up",   1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
`endif
    step_chk("wr_rst",  1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0);

    // Randomized traffic, starting from a reset so the model is in step
    m_cnt  = 0;
    m_wrap = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic         r, e, d;
      logic [W-1:0] sv;
      r  = (i == 0) || ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1) == 1;
      // Bias loads toward the ends so crossings are frequent
      case ($urandom_range(0, 3))
        0:       sv = 8'h00;
        1:       sv = 8'hFF;
        default: sv = W'($urandom);
      endcase
      model_edge(r, e, d, sv);
      step(r, e, d, sv);
      check($sformatf("rnd%0d.count", i), 32'(bus.count_out), 32'(m_cnt));
      check($sformatf("rnd%0d.wrap", i),  32'(bus.wrap),      32'(m_wrap));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
